// File: rtl/interp_pkg.sv
// interp_pkg
//   Shared definitions for the interpolator output sequencer:
//     SUM_W    - width of the interpolator A/B/C sums (two's complement)
//     PIX_MAX  - largest unsigned pixel value produced by saturation
//     phase_t  - 2-bit beat index (0=center, 1=A, 2=B, 3=C)
//     state_t  - sequencer states (IDLE, EMIT)
package interp_pkg;

  localparam int SUM_W   = 40;
  localparam int PIX_MAX = 255;

  typedef logic [1:0] phase_t;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

endpackage

// File: rtl/interp_norm_sat.sv
// interp_norm_sat
//   Combinational normalise-and-saturate stage. Sign-extends a SUM_W-bit
//   two's complement sum by one bit, adds an optional rounding bias,
//   arithmetic-shifts right by NORM_SHIFT and clamps to [0, PIX_MAX].
//
//   Build option:
//     INTERP_OUT_ROUND_EN - when defined, bias is 2^(NORM_SHIFT-1)
//                           (round half up); otherwise bias is 0 (floor).
//
//   Ports:
//     sum   in  [SUM_W-1:0]  signed interpolator sum
//     pixel out [7:0]        unsigned saturated pixel
module interp_norm_sat
  import interp_pkg::*;
#(
  parameter int NORM_SHIFT = 6
) (
  input  logic [SUM_W-1:0] sum,
  output logic [7:0]       pixel
);

`ifdef INTERP_OUT_ROUND_EN
  localparam logic signed [SUM_W:0] ROUND_TERM =
    $signed({{SUM_W{1'b0}}, 1'b1}) <<< (NORM_SHIFT - 1);
`else
  localparam logic signed [SUM_W:0] ROUND_TERM = '0;
`endif

  logic signed [SUM_W:0] biased;
  logic signed [SUM_W:0] shifted;

  // The extra sign bit keeps the rounding add from overflowing even for the
  // most positive sum, so the clamp below only has to look at the sign and
  // at whether anything is set above the pixel byte.
  always_comb begin
    biased  = $signed({sum[SUM_W-1], sum}) + ROUND_TERM;
    shifted = biased >>> NORM_SHIFT;
    if (shifted[SUM_W]) begin
      pixel = '0;
    end else if (|shifted[SUM_W-1:8]) begin
      pixel = 8'(PIX_MAX);
    end else begin
      pixel = shifted[7:0];
    end
  end

endmodule

// File: rtl/interp_out_seq.sv
// interp_out_seq
//   Serialises one interpolator window result into four pixel beats:
//   phase 0 = original center sample, phases 1..3 = normalised and
//   saturated A, B, C sums. A window is captured into holding registers on
//   accept; beats follow with valid/ready flow control. A new window may be
//   accepted on the final beat's handshake so back-to-back windows stream
//   without a bubble.
//
//   Build option:
//     INTERP_OUT_ROUND_EN - round half up in the normalise stage
//                           (default: floor).
//
//   Ports:
//     clock      in       sole clock, rising edge
//     reset      in       asynchronous active-high reset
//     in_valid   in       window presented on a_val/b_val/c_val/center
//     in_ready   out      window accepted this cycle when in_valid is high
//     a_val      in  [39:0] A sum, two's complement
//     b_val      in  [39:0] B sum, two's complement
//     c_val      in  [39:0] C sum, two's complement
//     center     in  [7:0]  original sample (window tap 4)
//     out_valid  out      out_pixel is valid
//     out_ready  in       downstream accepts the beat
//     out_pixel  out [7:0] unsigned pixel
//     out_phase  out [1:0] beat index
//     out_last   out      high on phase 3
module interp_out_seq
  import interp_pkg::*;
#(
  parameter int NORM_SHIFT = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SUM_W-1:0] a_val,
  input  logic [SUM_W-1:0] b_val,
  input  logic [SUM_W-1:0] c_val,
  input  logic [7:0]       center,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_pixel,
  output logic [1:0]       out_phase,
  output logic             out_last
);

  state_t           state;
  state_t           state_next;
  phase_t           phase;
  phase_t           phase_next;

  logic [SUM_W-1:0] a_q;
  logic [SUM_W-1:0] b_q;
  logic [SUM_W-1:0] c_q;
  logic [7:0]       center_q;

  logic             accept;
  logic             fire;
  logic             last_fire;
  logic [SUM_W-1:0] sel_sum;
  logic [7:0]       norm_pixel;

  assign accept    = in_valid && in_ready;
  assign fire      = out_valid && out_ready;
  assign last_fire = fire && (phase == 2'd3);

  // State and phase registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      phase <= '0;
    end else begin
      state <= state_next;
      phase <= phase_next;
    end
  end

  // Next state and phase. An accept always restarts at phase 0, which also
  // covers the overlapped accept on the last beat; otherwise the phase only
  // moves on a completed handshake and returns to 0 when the window ends.
  always_comb begin
    state_next = state;
    phase_next = phase;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = EMIT;
          phase_next = '0;
        end
      end
      EMIT: begin
        if (last_fire) begin
          phase_next = '0;
          if (!accept) begin
            state_next = IDLE;
          end
        end else if (fire) begin
          phase_next = phase + 2'd1;
        end
      end
      default: begin
        state_next = IDLE;
        phase_next = '0;
      end
    endcase
  end

  // Holding registers: the inputs only matter in the accept cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= '0;
      center_q <= '0;
    end else if (accept) begin
      a_q      <= a_val;
      b_q      <= b_val;
      c_q      <= c_val;
      center_q <= center;
    end
  end

  // Outputs. in_ready is masked by reset so nothing is accepted while reset
  // is held; the reset state already forces the other outputs to zero.
  always_comb begin
    out_valid = (state == EMIT);
    in_ready  = !reset && ((state == IDLE) || last_fire);
    out_phase = phase;
    out_last  = (phase == 2'd3);
    case (phase)
      2'd1:    sel_sum = a_q;
      2'd2:    sel_sum = b_q;
      default: sel_sum = c_q;
    endcase
    out_pixel = (phase == 2'd0) ? center_q : norm_pixel;
  end

  interp_norm_sat #(
    .NORM_SHIFT(NORM_SHIFT)
  ) u_norm_sat (
    .sum  (sel_sum),
    .pixel(norm_pixel)
  );

endmodule

// File: tb/tb_interp_out_seq.sv
// tb_interp_out_seq
//   Self-checking bench for interp_out_seq (NORM_SHIFT = 6). Stimulus pushes
//   hand-computed beats into a scoreboard queue; a negedge monitor pops and
//   compares every accepted output beat. Expected pixels for the rounding
//   case follow INTERP_OUT_ROUND_EN.
module tb_interp_out_seq;

  typedef struct {
    logic [7:0] pix;
    logic [1:0] ph;
    logic       last;
  } beat_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [39:0] a_val;
  logic [39:0] b_val;
  logic [39:0] c_val;
  logic [7:0]  center;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_pixel;
  logic [1:0]  out_phase;
  logic        out_last;

  int          tests = 0;
  int          fails = 0;
  beat_t       sb[$];

  logic        prev_stall = 1'b0;
  logic [7:0]  prev_pix   = '0;
  logic [1:0]  prev_phase = '0;

`ifdef INTERP_OUT_ROUND_EN
  localparam logic [7:0] RND_A = 8'd2;
  localparam logic [7:0] RND_B = 8'd1;
  localparam logic [7:0] RND_C = 8'd1;
`else
  localparam logic [7:0] RND_A = 8'd1;
  localparam logic [7:0] RND_B = 8'd1;
  localparam logic [7:0] RND_C = 8'd0;
`endif

  interp_out_seq #(
    .NORM_SHIFT(6)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a_val    (a_val),
    .b_val    (b_val),
    .c_val    (c_val),
    .center   (center),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_pixel(out_pixel),
    .out_phase(out_phase),
    .out_last (out_last)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic pushWindow(input logic [7:0] ctr, input logic [7:0] e1,
                            input logic [7:0] e2, input logic [7:0] e3);
    sb.push_back('{pix: ctr, ph: 2'd0, last: 1'b0});
    sb.push_back('{pix: e1,  ph: 2'd1, last: 1'b0});
    sb.push_back('{pix: e2,  ph: 2'd2, last: 1'b0});
    sb.push_back('{pix: e3,  ph: 2'd3, last: 1'b1});
  endtask

  // Presents a window, waits (bounded) for acceptance, records the expected
  // beats and returns just after the accepting clock edge with garbage on
  // the data inputs so the holding registers are what gets emitted.
  task automatic applyStimulus(input logic [7:0] ctr, input logic [39:0] a,
                               input logic [39:0] b, input logic [39:0] c,
                               input logic [7:0] e1, input logic [7:0] e2,
                               input logic [7:0] e3);
    bit got = 1'b0;
    center   = ctr;
    a_val    = a;
    b_val    = b;
    c_val    = c;
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (in_ready) begin
        got = 1'b1;
        break;
      end
    end
    checkOutput("accept_wait", 32'(got), 32'd1);
    if (got) pushWindow(ctr, e1, e2, e3);
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    center   = 8'hEE;
    a_val    = 40'h7F_FFFF_FFFF;
    b_val    = 40'h80_0000_0000;
    c_val    = 40'h12_3456_789A;
  endtask

  task automatic drainQueue();
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      #1;
      if (sb.size() == 0) break;
    end
    checkOutput("drain_empty", 32'(sb.size()), 32'd0);
    @(negedge clock);
    checkOutput("idle_after_drain", 32'(out_valid), 32'd0);
  endtask

  // Scoreboard monitor plus stall-stability check.
  always @(negedge clock) begin
    beat_t exp;
    if (!reset && prev_stall && out_valid) begin
      checkOutput("stall_pixel_stable", 32'(out_pixel), 32'(prev_pix));
      checkOutput("stall_phase_stable", 32'(out_phase), 32'(prev_phase));
    end
    if (!reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("[TB] FAIL unexpected_beat: got pixel %0h phase %0d expected no beat",
                 out_pixel, out_phase);
      end else begin
        exp = sb.pop_front();
        checkOutput("beat_pixel", 32'(out_pixel), 32'(exp.pix));
        checkOutput("beat_phase", 32'(out_phase), 32'(exp.ph));
        checkOutput("beat_last",  32'(out_last),  32'(exp.last));
      end
    end
    prev_stall = !reset && out_valid && !out_ready;
    prev_pix   = out_pixel;
    prev_phase = out_phase;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    center    = '0;
    a_val     = '0;
    b_val     = '0;
    c_val     = '0;
    #1 reset  = 1'b1;
    #2;

    // Reset state
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_in_ready",  32'(in_ready),  32'd0);
    checkOutput("rst_out_pixel", 32'(out_pixel), 32'd0);
    checkOutput("rst_out_last",  32'(out_last),  32'd0);
    checkOutput("rst_out_phase", 32'(out_phase), 32'd0);
    repeat (3) @(posedge clock);
    @(negedge clock);
    checkOutput("rst_held_in_ready", 32'(in_ready), 32'd0);
    #2 reset = 1'b0;
    #1;
    checkOutput("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Main window, continuous ready, beat-per-cycle timing
    @(posedge clock);
    #1;
    out_ready = 1'b1;
    applyStimulus(8'h55, 40'd6400, -40'sd64, 40'd19200, 8'd100, 8'd0, 8'd255);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      checkOutput("main_valid", 32'(out_valid), 32'd1);
      checkOutput("main_phase", 32'(out_phase), 32'(i));
    end
    @(negedge clock);
    checkOutput("main_valid_done", 32'(out_valid), 32'd0);
    checkOutput("main_sb_empty", 32'(sb.size()), 32'd0);

    // Rounding behaviour
    @(posedge clock);
    #1;
    applyStimulus(8'h12, 40'd96, 40'd95, 40'd32, RND_A, RND_B, RND_C);
    drainQueue();

    // Three-cycle stall on phase 1
    @(posedge clock);
    #1;
    applyStimulus(8'h33, 40'd640, 40'd1280, -40'sd1, 8'd10, 8'd20, 8'd0);
    @(negedge clock);
    checkOutput("stall_p0_phase", 32'(out_phase), 32'd0);
    @(posedge clock);
    #1 out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      checkOutput("stall_valid", 32'(out_valid), 32'd1);
      checkOutput("stall_phase", 32'(out_phase), 32'd1);
      checkOutput("stall_pixel", 32'(out_pixel), 32'd10);
    end
    @(posedge clock);
    #1 out_ready = 1'b1;
    drainQueue();

    // Back-to-back windows overlapped on the last handshake
    @(posedge clock);
    #1;
    applyStimulus(8'h11, 40'd64, 40'd128, 40'd192, 8'd1, 8'd2, 8'd3);
    center   = 8'h22;
    a_val    = 40'd256;
    b_val    = 40'd320;
    c_val    = 40'd384;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      checkOutput("b2b_valid", 32'(out_valid), 32'd1);
      checkOutput("b2b_no_early_ready", 32'(in_ready), 32'd0);
    end
    @(negedge clock);
    checkOutput("b2b_last_valid", 32'(out_valid), 32'd1);
    checkOutput("b2b_last_phase", 32'(out_phase), 32'd3);
    checkOutput("b2b_in_ready", 32'(in_ready), 32'd1);
    pushWindow(8'h22, 8'd4, 8'd5, 8'd6);
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    @(negedge clock);
    checkOutput("b2b_next_valid", 32'(out_valid), 32'd1);
    checkOutput("b2b_next_phase", 32'(out_phase), 32'd0);
    checkOutput("b2b_next_pixel", 32'(out_pixel), 32'h22);
    drainQueue();

    // Reset during phase 2
    @(posedge clock);
    #1;
    applyStimulus(8'h44, 40'd64, 40'd128, 40'd192, 8'd1, 8'd2, 8'd3);
    @(negedge clock);
    @(negedge clock);
    @(posedge clock);
    #2 reset = 1'b1;
    #1;
    checkOutput("midrst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("midrst_in_ready",  32'(in_ready),  32'd0);
    checkOutput("midrst_out_pixel", 32'(out_pixel), 32'd0);
    checkOutput("midrst_out_phase", 32'(out_phase), 32'd0);
    checkOutput("midrst_sb_left",   32'(sb.size()), 32'd2);
    sb.delete();
    @(negedge clock);
    #2 reset = 1'b0;
    #1;
    checkOutput("midrst_release_ready", 32'(in_ready), 32'd1);
    @(posedge clock);
    #1;
    checkOutput("midrst_idle_valid", 32'(out_valid), 32'd0);
    applyStimulus(8'h66, 40'd128, 40'd192, 40'd256, 8'd2, 8'd3, 8'd4);
    @(negedge clock);
    checkOutput("midrst_restart_phase", 32'(out_phase), 32'd0);
    checkOutput("midrst_restart_pixel", 32'(out_pixel), 32'h66);
    drainQueue();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
